// File: rtl/thermostat_controller_if.sv
// Thermostat controller I/O bundle.
// Buttons, mode and temperature in; setpoint, enables and state out.
interface thermostat_controller_if;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] mode;
  logic [7:0] current_temp;
  logic [7:0] set_temp;
  logic       heat_on;
  logic       cool_on;
  logic       fan_on;
  logic [1:0] state;

  modport master (
    output btn_up,
    output btn_down,
    output mode,
    output current_temp,
    input  set_temp,
    input  heat_on,
    input  cool_on,
    input  fan_on,
    input  state
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  mode,
    input  current_temp,
    output set_temp,
    output heat_on,
    output cool_on,
    output fan_on,
    output state
  );
endinterface

// File: rtl/thermostat_controller.sv
// Thermostat sequencing controller: setpoint buttons with auto-repeat,
// heat/cool/idle FSM with hysteresis, minimum run and lockout timers.
module thermostat_controller #(
  parameter int TICK_DIV     = 100000,
  parameter int TEMP_MIN     = 50,
  parameter int TEMP_MAX     = 90,
  parameter int TEMP_RESET   = 72,
  parameter int HYST         = 1,
  parameter int MIN_RUN      = 60000,
  parameter int MIN_OFF      = 30000,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 150
) (
  input logic                    clk,
  input logic                    reset,
  thermostat_controller_if.slave bus
);

  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_MAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int RUN_MAX =
    (MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF;
  localparam int RW = $clog2(RUN_MAX + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] RUN_LIM    = RW'(MIN_RUN);
  localparam logic [RW-1:0] OFF_LIM    = RW'(MIN_OFF);
  localparam logic [RW-1:0] RUN_SAT    = {RW{1'b1}};

  localparam logic [7:0] T_MIN = 8'(TEMP_MIN);
  localparam logic [7:0] T_MAX = 8'(TEMP_MAX);
  localparam logic [7:0] T_RST = 8'(TEMP_RESET);

  localparam logic signed [9:0] HYST_S = 10'(HYST);

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_HEAT = 2'd1;
  localparam logic [1:0] M_COOL = 2'd2;
  localparam logic [1:0] M_AUTO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEATING = 2'd1,
    COOLING = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  logic [TW-1:0] div_q;
  logic          tick;

  logic [2:0]    up_sh;
  logic [2:0]    dn_sh;
  logic          up_s;
  logic          up_p;
  logic          dn_s;
  logic          dn_p;
  logic          one_held;
  logic          press;

  logic [HW-1:0] hold_q;
  logic          rep_q;
  logic [HW-1:0] hold_lim;
  logic          hold_fire;
  logic          step_up;
  logic          step_dn;

  logic [7:0]    sp_q;

  logic signed [9:0] cur_s;
  logic signed [9:0] set_s;
  logic          cold;
  logic          hot;
  logic          at_or_above;
  logic          at_or_below;
  logic          heat_ok;
  logic          cool_ok;
  logic          mode_off;
  logic          mode_heat;
  logic          mode_cool;

  state_t        state_q;
  logic [RW-1:0] run_q;
  logic          run_done;
  logic          off_done;
  logic          heat_q;
  logic          cool_q;
  logic          fan_q;

  // Free-running tick divider, one-cycle pulse at the top count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + TW'(1);
    end
  end

  assign tick = (div_q == TICK_LAST);

  // Two-flop synchronizers plus a previous-value flop for edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_sh <= '0;
      dn_sh <= '0;
    end else begin
      up_sh <= {up_sh[1:0], bus.btn_up};
      dn_sh <= {dn_sh[1:0], bus.btn_down};
    end
  end

  assign up_s = up_sh[1];
  assign up_p = up_sh[2];
  assign dn_s = dn_sh[1];
  assign dn_p = dn_sh[2];

  // Exactly one button held; both held counts as no press
  assign one_held = up_s ^ dn_s;
  assign press    = (up_s & ~up_p) | (dn_s & ~dn_p);
  assign hold_lim = rep_q ? RATE_LAST : DELAY_LAST;

  assign hold_fire = one_held & ~press & tick &
                     (hold_q == hold_lim);

  // Hold timer: initial delay, then periodic repeat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else if (!one_held || press) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else if (hold_fire) begin
      hold_q <= '0;
      rep_q  <= 1'b1;
    end else if (tick) begin
      hold_q <= hold_q + HW'(1);
    end
  end

  assign step_up = up_s & ~dn_s & (~up_p | hold_fire);
  assign step_dn = dn_s & ~up_s & (~dn_p | hold_fire);

  // Setpoint register, saturating at the legal range ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= T_RST;
    end else if (step_up && sp_q < T_MAX) begin
      sp_q <= sp_q + 8'd1;
    end else if (step_dn && sp_q > T_MIN) begin
      sp_q <= sp_q - 8'd1;
    end
  end

  // Widened signed compare so set_temp +/- HYST never wraps
  assign cur_s = signed'({2'b00, bus.current_temp});
  assign set_s = signed'({2'b00, sp_q});
  assign cold  = (cur_s <= set_s - HYST_S);
  assign hot   = (cur_s >= set_s + HYST_S);

  assign at_or_above = (bus.current_temp >= sp_q);
  assign at_or_below = (bus.current_temp <= sp_q);

  assign mode_off  = (bus.mode == M_OFF);
  assign mode_heat = (bus.mode == M_HEAT);
  assign mode_cool = (bus.mode == M_COOL);
  assign heat_ok   = mode_heat | (bus.mode == M_AUTO);
  assign cool_ok   = mode_cool | (bus.mode == M_AUTO);

  assign run_done = (run_q >= RUN_LIM);
  assign off_done = (run_q >= OFF_LIM);

  // Heat/cool/idle sequencing with run and lockout timers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      fan_q   <= 1'b0;
    end else begin
      if (tick && run_q != RUN_SAT) begin
        run_q <= run_q + RW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (cold && heat_ok) begin
            state_q <= HEATING;
            run_q   <= '0;
            heat_q  <= 1'b1;
            fan_q   <= 1'b1;
          end else if (hot && cool_ok) begin
            state_q <= COOLING;
            run_q   <= '0;
            cool_q  <= 1'b1;
            fan_q   <= 1'b1;
          end
        end
        HEATING: begin
          if (mode_off ||
              (run_done && (at_or_above || mode_cool))) begin
            state_q <= LOCKOUT;
            run_q   <= '0;
            heat_q  <= 1'b0;
            fan_q   <= 1'b0;
          end
        end
        COOLING: begin
          if (mode_off ||
              (run_done && (at_or_below || mode_heat))) begin
            state_q <= LOCKOUT;
            run_q   <= '0;
            cool_q  <= 1'b0;
            fan_q   <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (off_done) begin
            state_q <= IDLE;
            run_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.set_temp = sp_q;
  assign bus.state    = state_q;
  assign bus.heat_on  = heat_q;
  assign bus.cool_on  = cool_q;
  assign bus.fan_on   = fan_q;

endmodule

// File: tb/tb_thermostat_controller.sv
// Bench for thermostat_controller: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model.
module tb_thermostat_controller;

  localparam int TD   = 4;
  localparam int TMIN = 50;
  localparam int TMAX = 90;
  localparam int TR   = 72;
  localparam int HY   = 1;
  localparam int MR   = 3;
  localparam int MO   = 2;
  localparam int RD   = 5;
  localparam int RR   = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  thermostat_controller_if bus();

  thermostat_controller #(
    .TICK_DIV    (TD),
    .TEMP_MIN    (TMIN),
    .TEMP_MAX    (TMAX),
    .TEMP_RESET  (TR),
    .HYST        (HY),
    .MIN_RUN     (MR),
    .MIN_OFF     (MO),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: setpoint, state (0..3), ticks in state,
  // ticks held, cycles since reset, raw button history
  int m_set;
  int m_state;
  int m_run;
  int m_held;
  int m_cyc;
  bit uh[3];
  bit dh[3];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_set   = TR;
    m_state = 0;
    m_run   = 0;
    m_held  = 0;
    m_cyc   = 0;
    for (int i = 0; i < 3; i++) begin
      uh[i] = 1'b0;
      dh[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tk, us, ds, one, rise, fire;
    bit su, sd, cold, hot;
    int nxt, cur, md;
    tk   = (m_cyc % TD) == TD - 1;
    // synced value lags raw by two edges
    us   = uh[1];
    ds   = dh[1];
    one  = (us != ds);
    rise = (us && !uh[2]) || (ds && !dh[2]);
    fire = 1'b0;
    if (!one || rise) begin
      m_held = 0;
    end else if (tk) begin
      m_held++;
      fire = (m_held == RD) ||
             (m_held > RD && (m_held - RD) % RR == 0);
    end
    su   = one && us && (rise || fire);
    sd   = one && ds && (rise || fire);
    cur  = int'(bus.current_temp);
    md   = int'(bus.mode);
    cold = cur <= m_set - HY;
    hot  = cur >= m_set + HY;
    nxt  = m_state;
    case (m_state)
      0: begin
        if (cold && (md == 1 || md == 3)) nxt = 1;
        else if (hot && (md == 2 || md == 3)) nxt = 2;
      end
      1: begin
        if (md == 0) nxt = 3;
        else if (m_run >= MR && (cur >= m_set || md == 2))
          nxt = 3;
      end
      2: begin
        if (md == 0) nxt = 3;
        else if (m_run >= MR && (cur <= m_set || md == 1))
          nxt = 3;
      end
      default: begin
        if (m_run >= MO) nxt = 0;
      end
    endcase
    if (nxt != m_state) m_run = 0;
    else if (tk) m_run++;
    m_state = nxt;
    if (su && m_set < TMAX) m_set++;
    else if (sd && m_set > TMIN) m_set--;
    uh[2] = uh[1];
    uh[1] = uh[0];
    uh[0] = bus.btn_up;
    dh[2] = dh[1];
    dh[1] = dh[0];
    dh[0] = bus.btn_down;
    m_cyc++;
  endtask

  task automatic compare_all();
    chk("set_temp", bus.set_temp, m_set);
    chk("state", bus.state, m_state);
    chk("heat_on", bus.heat_on, m_state == 1);
    chk("cool_on", bus.cool_on, m_state == 2);
    chk("fan_on", bus.fan_on,
        m_state == 1 || m_state == 2);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // asynchronous reset between edges; buttons released with it
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("async_set", bus.set_temp, TR);
    chk("async_state", bus.state, 0);
    chk("async_fan", bus.fan_on, 0);
    model_reset();
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic press_up(input int hi, input int lo);
    bus.btn_up = 1'b1;
    repeat (hi) cyc();
    bus.btn_up = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic press_dn(input int hi, input int lo);
    bus.btn_down = 1'b1;
    repeat (hi) cyc();
    bus.btn_down = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic wait_state(input string tag,
                            input int s,
                            input int budget);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, bus.state, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.btn_up       = 1'b0;
    bus.btn_down     = 1'b0;
    bus.mode         = 2'd0;
    bus.current_temp = 8'd72;

    // reset values and single presses
    do_reset();
    chk("rst_set", bus.set_temp, 72);
    chk("rst_state", bus.state, 0);
    chk("rst_fan", bus.fan_on, 0);
    repeat (3) press_up(3, 3);
    chk("p1_up3", bus.set_temp, 75);

    // hold down about nine ticks: press + ticks 5, 7, 9
    press_dn(38, 5);
    chk("p1_hold", bus.set_temp, 71);

    // reset in the middle of a hold
    bus.btn_down = 1'b1;
    repeat (12) cyc();
    async_reset();
    repeat (4) cyc();
    chk("p1_after_rst", bus.set_temp, 72);

    // saturation at the top and both buttons held
    repeat (45) press_up(2, 2);
    repeat (4) cyc();
    chk("p2_sat", bus.set_temp, 90);
    press_up(2, 4);
    chk("p2_sat_again", bus.set_temp, 90);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    repeat (40) cyc();
    chk("p2_both", bus.set_temp, 90);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (4) cyc();
    chk("p2_both_rel", bus.set_temp, 90);

    // heating with minimum run, lockout, idle
    do_reset();
    bus.mode         = 2'd1;
    bus.current_temp = 8'd71;
    cyc();
    chk("p3_heat", bus.state, 1);
    chk("p3_heat_on", bus.heat_on, 1);
    chk("p3_fan_on", bus.fan_on, 1);
    bus.current_temp = 8'd72;
    repeat (7) cyc();
    chk("p3_min_run", bus.state, 1);
    wait_state("p3_lock", 3, 12);
    chk("p3_lock_heat", bus.heat_on, 0);
    wait_state("p3_idle", 0, 12);
    repeat (5) cyc();
    chk("p3_stay_idle", bus.state, 0);

    // cooling cut by OFF, lockout cannot be shortened
    bus.mode         = 2'd3;
    bus.current_temp = 8'd73;
    cyc();
    chk("p4_cool", bus.state, 2);
    chk("p4_cool_on", bus.cool_on, 1);
    repeat (4) cyc();
    bus.mode = 2'd0;
    cyc();
    chk("p4_off_lock", bus.state, 3);
    chk("p4_cool_off", bus.cool_on, 0);
    bus.mode         = 2'd3;
    bus.current_temp = 8'd90;
    repeat (2) cyc();
    chk("p4_lock_hold", bus.state, 3);
    wait_state("p4_idle", 0, 12);
    wait_state("p4_recool", 2, 4);

    // boundaries: equal temperature, no wrap near zero
    do_reset();
    bus.mode         = 2'd3;
    bus.current_temp = 8'd72;
    repeat (10) cyc();
    chk("p5_equal", bus.state, 0);
    bus.mode = 2'd0;
    repeat (22) press_dn(2, 2);
    repeat (4) cyc();
    chk("p5_min", bus.set_temp, 50);
    press_dn(2, 4);
    chk("p5_min_sat", bus.set_temp, 50);
    bus.mode         = 2'd2;
    bus.current_temp = 8'd0;
    repeat (10) cyc();
    chk("p5_nowrap", bus.state, 0);

    // mode flip to COOL during a heating run
    do_reset();
    bus.mode         = 2'd1;
    bus.current_temp = 8'd60;
    cyc();
    chk("p6_heat", bus.state, 1);
    bus.mode         = 2'd2;
    bus.current_temp = 8'd90;
    repeat (6) cyc();
    chk("p6_min_run", bus.state, 1);
    wait_state("p6_lock", 3, 12);
    wait_state("p6_idle", 0, 12);
    wait_state("p6_cool", 2, 4);

    // random soak against the model
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0)
        bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 9) == 0)
          bus.current_temp = 8'($urandom_range(0, 255));
        else
          bus.current_temp = 8'($urandom_range(45, 95));
      end
      if ($urandom_range(0, 29) == 0)
        bus.btn_up = ~bus.btn_up;
      if ($urandom_range(0, 29) == 0)
        bus.btn_down = ~bus.btn_down;
      if ($urandom_range(0, 599) == 0) async_reset();
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/thermostat_controller.md
Name: thermostat_controller

Overview:
Sequencing controller for the thermostat datapath. It owns the user setpoint, adjusted by up/down buttons with auto-repeat and clamped to a legal range. It runs the heat/cool/idle state machine against the measured temperature, with hysteresis and compressor-protection timers. Its set_temp output feeds the seven-segment display's ChangedTemp input, and its current_temp input is the same value shown as CurrentTemp.

Parameters:
TICK_DIV, 100000, clk cycles per timer tick (1 ms at 100 MHz)
TEMP_MIN, 50, lowest legal setpoint (degF)
TEMP_MAX, 90, highest legal setpoint (degF)
TEMP_RESET, 72, setpoint after reset; TEMP_MIN <= TEMP_RESET <= TEMP_MAX
HYST, 1, hysteresis band (degF)
MIN_RUN, 60000, minimum HEATING/COOLING duration (ticks)
MIN_OFF, 30000, LOCKOUT duration (ticks)
REPEAT_DELAY, 500, hold time before auto-repeat starts (ticks)
REPEAT_RATE, 150, auto-repeat period (ticks)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
btn_up  in  1  raise setpoint, asynchronous, debounced
btn_down  in  1  lower setpoint, asynchronous, debounced
mode  in  2  0=OFF 1=HEAT 2=COOL 3=AUTO
current_temp  in  8  measured temperature (degF, unsigned)
set_temp  out  8  setpoint, to display ChangedTemp
heat_on  out  1  heater enable
cool_on  out  1  cooler enable
fan_on  out  1  heat_on | cool_on
state  out  2  0=IDLE 1=HEATING 2=COOLING 3=LOCKOUT

Behaviour:
- All outputs registered. Reset is asynchronous and takes effect immediately, including mid-operation:
  - set_temp=TEMP_RESET, state=IDLE, heat_on=cool_on=fan_on=0.
  - Tick, repeat and run counters cleared; sync flops cleared.
- Tick: free-running divider 0..TICK_DIV-1. A one-cycle tick pulse is asserted when the divider equals TICK_DIV-1, then the divider wraps to 0.
- Buttons:
  - Two-flop synchronizer per button.
  - Rising edge of a synced button is a step event.
  - While held, a hold counter advances on ticks. At REPEAT_DELAY it issues a step and reloads; each further REPEAT_RATE ticks issues another step.
  - Release clears the hold counter.
  - Both synced buttons high: no steps, hold counter held at 0.
- Setpoint arithmetic:
  - Up step: set_temp+1 if < TEMP_MAX, else unchanged (saturate). Down step mirrors this with TEMP_MIN.
  - set_temp updates on the cycle after the step.
- Comparisons use 10-bit signed arithmetic (no wrap near 0/255):
  - cold = current_temp <= set_temp-HYST
  - hot = current_temp >= set_temp+HYST
- FSM (evaluated every clk, one-cycle latency to outputs):
  - IDLE:
    - cold and mode in {HEAT,AUTO} -> HEATING.
    - Else hot and mode in {COOL,AUTO} -> COOLING.
    - Heat takes priority if both conditions are true.
  - HEATING (heat_on=1):
    - mode==OFF -> LOCKOUT immediately.
    - Else, once run count >= MIN_RUN: current_temp >= set_temp, or mode==COOL -> LOCKOUT.
    - Setpoint changes during a run are honoured only through this exit test.
  - COOLING (cool_on=1): symmetric to HEATING. Exit when current_temp <= set_temp, or mode==HEAT, after MIN_RUN; mode==OFF exits immediately.
  - LOCKOUT (all enables 0): run count cleared on entry, counts ticks. Reaching MIN_OFF -> IDLE. Cannot be shortened by mode or setpoint.
- Run counter: cleared on every state entry, increments on tick, saturates.
- No direct HEATING<->COOLING transition; LOCKOUT always intervenes.
- fan_on, heat_on and cool_on change in the same cycle as state.

Test Plan:
Bench params: TICK_DIV=4, MIN_RUN=3, MIN_OFF=2, REPEAT_DELAY=5, REPEAT_RATE=2, HYST=1, TEMP_RESET=72.
1. Reset then 3 single btn_up pulses -> set_temp 72->75. Hold btn_down 9 ticks -> 1 step at press, 1 at tick 5, 1 at tick 7, 1 at tick 9, set_temp=71. Assert reset mid-hold -> set_temp=72 immediately.
2. Saturation: 45 btn_up presses -> set_temp=90, stays 90. Both buttons held -> no change.
3. mode=HEAT, set_temp=72, current_temp=71 -> state=HEATING, heat_on=fan_on=1 next cycle. current_temp=72 at tick 1 -> remains HEATING until run count 3, then LOCKOUT for 2 ticks, then IDLE.
4. mode=AUTO, current_temp=73 -> COOLING. mode=OFF at tick 1 -> LOCKOUT next cycle, cool_on=0. mode=AUTO and current_temp=90 during LOCKOUT -> no exit before 2 ticks, then IDLE, then COOLING.
5. Boundaries: set_temp=72, current_temp=72 in AUTO -> stays IDLE. current_temp=0 with set_temp=50, mode=COOL -> stays IDLE (no unsigned wrap).
6. mode=HEAT, HEATING, then mode=COOL before MIN_RUN -> stays HEATING until run count 3, then LOCKOUT, then IDLE, then COOLING if hot.
